branch_resolve_ctrl: RTL and testbench
======================================

# branch_resolve_ctrl

Branch-resolution controller for the EX stage of the RV32I core. It accepts one conditional branch at a time from EX and configures the branch comparator (BrUn). It then evaluates the taken/not-taken outcome from BrEq/BrLT and trains a 2-bit-counter branch history table (BHT) that also serves fetch-stage predictions. On a misprediction it issues a PC redirect and holds a pipeline flush for a fixed number of cycles.

## Interface
- BHT_ENTRIES, 16, number of 2-bit counters; power of two, ≥2; index width IW = log2(BHT_ENTRIES).
- FLUSH_CYCLES, 2, cycles `flush` stays high after a mispredict; ≥1.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- br_valid  in  1  EX holds a valid conditional branch.
- br_ready  out  1  controller can accept a branch.
- br_funct3  in  3  branch funct3.
- br_pc  in  32  PC of the branch.
- br_target  in  32  computed branch target.
- br_pred_taken  in  1  prediction made at fetch, carried down the pipe.
- BrUn  out  1  comparator mode: 1 = unsigned compare.
- BrEq  in  1  comparator result: rs1 == rs2.
- BrLT  in  1  comparator result: rs1 < rs2, signed when BrUn = 0, unsigned when BrUn = 1.
- fetch_pc  in  32  fetch-stage PC for lookup.
- fetch_pred_taken  out  1  prediction for fetch_pc.
- br_done  out  1  one-cycle pulse; the outcome is resolved.
- br_taken  out  1  outcome; valid while br_done = 1.
- br_illegal  out  1  pulse together with br_done when funct3 is 010 or 011.
- redirect_valid  out  1  one-cycle pulse to load redirect_pc.
- redirect_pc  out  32  corrected PC.
- flush  out  1  squash IF/ID.
- br_count  out  CNT_W  legal branches resolved, wraps.
- mispred_count  out  CNT_W  mispredictions, wraps.

## Operation
- States: IDLE, EVAL, FLUSH.
- IDLE:
  - br_ready = 1.
  - On br_valid & br_ready, latch funct3, pc, target, pred_taken, then go to EVAL.
  - EX must hold rs1/rs2 stable until br_done.
- BrUn = latched funct3[1] in EVAL; 0 otherwise.
- EVAL:
  - taken is decided by funct3: 000 BEQ: BrEq; 001 BNE: !BrEq; 100/110 BLT/BLTU: BrLT; 101/111 BGE/BGEU: !BrLT.
  - 010/011: taken = 0 and br_illegal = 1.
- EVAL outputs:
  - br_done = 1 and br_taken = taken.
  - mispredict = taken ≠ pred_taken.
  - br_count += 1 if the funct3 is legal.
  - mispred_count += 1 on a mispredict; illegal branches also count.
- EVAL next state: FLUSH on a mispredict, else IDLE.
- Redirect:
  - On entering FLUSH, register redirect_pc = taken ? target : pc + 4 (32-bit wrap).
  - redirect_valid is high for exactly the first FLUSH cycle.
  - flush is high for all FLUSH_CYCLES cycles, then the state returns to IDLE.
- BHT:
  - Entry index = pc[IW+1:2]; every entry resets to 01.
  - Counter update happens at the end of EVAL, for legal branches only: taken → saturating increment (max 11); not taken → saturating decrement (min 00).
  - fetch_pred_taken = bit 1 of entry fetch_pc[IW+1:2], read combinationally.
  - A read of the entry being written in the same cycle returns the pre-write value.
- br_valid is ignored outside IDLE.

## Timing
- Accept at cycle T; EVAL is T+1; br_done is combinational in T+1.
- Correct prediction: IDLE at T+2; the next branch can be accepted in T+2, giving throughput of 1 branch per 2 cycles.
- Mispredict:
  - redirect_valid and flush both high at T+2.
  - flush stays high through T+1+FLUSH_CYCLES.
  - IDLE with br_ready = 1 at T+2+FLUSH_CYCLES.
- Reset (rst_n = 0 at an edge):
  - Next state is IDLE.
  - BHT is all 01; br_count and mispred_count are 0.
  - redirect_pc is 0; redirect_valid, flush, br_done, br_taken, br_illegal and BrUn are 0.
- br_ready = (state == IDLE) & rst_n.
- Reset asserted in EVAL or FLUSH aborts immediately: no redirect, no counter or BHT update from the aborted branch.
- Counter wrap: all-ones + 1 → 0, with no sticky flag.

## Test plan
- Reset with all entries at 01: BEQ at pc 0x100, BrEq = 1, pred = 0 → br_done and br_taken at T+1. At T+2, redirect_valid = 1 with redirect_pc = target (0x140); flush stays high for 2 cycles. Entry 0 becomes 10 and mispred_count = 1.
- BLTU, BrEq = 0, BrLT = 0, pred = 0 → BrUn = 1 in EVAL, not taken, no flush, br_ready = 1 at T+2, br_count += 1.
- Train pc 0x104 with three taken BNEs → entry 1 saturates at 11 and fetch_pred_taken(0x104) = 1. Then resolve one not-taken BNE with pred = 1 → entry goes to 10 and redirect_pc = 0x108.
- funct3 = 010 with pred = 1 → br_illegal = 1, taken = 0, redirect to pc + 4, BHT unchanged, br_count unchanged, mispred_count += 1.
- Assert rst_n = 0 in the first FLUSH cycle → next cycle flush = 0, the state is IDLE, and the counters are 0. Also confirm br_valid is ignored while in FLUSH.
- Preload br_count = 0xFFFF (drive 65535 legal branches) → the next legal branch wraps it to 0x0000. Also confirm a same-index fetch lookup during EVAL returns the old counter value.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// Branch-resolution controller for the EX stage: accepts one conditional
// branch at a time, steers the comparator mode, resolves taken/not-taken,
// trains a 2-bit-counter BHT shared with fetch, and issues a PC redirect
// plus a fixed-length IF/ID flush on a misprediction.
module branch_resolve_ctrl #(
    parameter int unsigned BHT_ENTRIES  = 16,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_funct3,
    input  logic [31:0]       br_pc,
    input  logic [31:0]       br_target,
    input  logic              br_pred_taken,
    output logic              BrUn,
    input  logic              BrEq,
    input  logic              BrLT,
    input  logic [31:0]       fetch_pc,
    output logic              fetch_pred_taken,
    output logic              br_done,
    output logic              br_taken,
    output logic              br_illegal,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    output logic              flush,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  mispred_count
);

    localparam int unsigned IW = $clog2(BHT_ENTRIES);
    localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_FLUSH
    } state_t;

    state_t           r_state;
    logic [2:0]       r_funct3;
    logic [31:0]      r_pc;
    logic [31:0]      r_target;
    logic             r_pred;
    logic [1:0]       r_bht [BHT_ENTRIES];
    logic [CNT_W-1:0] r_br_count;
    logic [CNT_W-1:0] r_mispred_count;
    logic [31:0]      r_redirect_pc;
    logic             r_redirect_valid;
    logic             r_flush;
    logic [FW-1:0]    r_flush_left;

    logic             w_eval;
    logic             w_legal;
    logic             w_taken;
    logic             w_mispredict;
    logic [IW-1:0]    w_idx;
    logic [IW-1:0]    w_fetch_idx;
    logic             w_unused_fetch;

    assign w_eval         = (r_state == S_EVAL) && rst_n;
    assign w_mispredict   = (w_taken != r_pred);
    assign w_idx          = r_pc[IW+1:2];
    assign w_fetch_idx    = fetch_pc[IW+1:2];
    assign w_unused_fetch = ^{fetch_pc[31:IW+2], fetch_pc[1:0]};

    // Decode the latched funct3 into legality and the taken outcome.
    always_comb begin
        w_legal = 1'b1;
        w_taken = 1'b0;
        case (r_funct3)
            3'b000:         w_taken = BrEq;
            3'b001:         w_taken = !BrEq;
            3'b100, 3'b110: w_taken = BrLT;
            3'b101, 3'b111: w_taken = !BrLT;
            default:        w_legal = 1'b0;
        endcase
    end

    assign br_ready         = (r_state == S_IDLE) && rst_n;
    assign BrUn             = w_eval && r_funct3[1];
    assign br_done          = w_eval;
    assign br_taken         = w_eval && w_taken;
    assign br_illegal       = w_eval && !w_legal;
    assign redirect_valid   = r_redirect_valid;
    assign redirect_pc      = r_redirect_pc;
    assign flush            = r_flush;
    assign br_count         = r_br_count;
    assign mispred_count    = r_mispred_count;
    // Plain array read: a same-cycle EVAL write is only visible after the edge.
    assign fetch_pred_taken = r_bht[w_fetch_idx][1];

    // Control FSM: accept, resolve, redirect/flush, plus statistics counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_funct3         <= '0;
            r_pc             <= '0;
            r_target         <= '0;
            r_pred           <= 1'b0;
            r_br_count       <= '0;
            r_mispred_count  <= '0;
            r_redirect_pc    <= '0;
            r_redirect_valid <= 1'b0;
            r_flush          <= 1'b0;
            r_flush_left     <= '0;
        end else begin
            r_redirect_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (br_valid) begin
                        r_funct3 <= br_funct3;
                        r_pc     <= br_pc;
                        r_target <= br_target;
                        r_pred   <= br_pred_taken;
                        r_state  <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (w_legal) begin
                        r_br_count <= r_br_count + CNT_W'(1);
                    end
                    if (w_mispredict) begin
                        r_mispred_count  <= r_mispred_count + CNT_W'(1);
                        r_redirect_pc    <= w_taken ? r_target : (r_pc + 32'd4);
                        r_redirect_valid <= 1'b1;
                        r_flush          <= 1'b1;
                        r_flush_left     <= FW'(FLUSH_CYCLES - 1);
                        r_state          <= S_FLUSH;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (r_flush_left == '0) begin
                        r_flush <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_flush_left <= r_flush_left - FW'(1);
                    end
                end
                default: begin
                    r_flush <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // BHT training: saturating 2-bit counter update at the end of EVAL, legal branches only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if ((r_state == S_EVAL) && w_legal) begin
            if (w_taken) begin
                if (r_bht[w_idx] != 2'b11) begin
                    r_bht[w_idx] <= r_bht[w_idx] + 2'd1;
                end
            end else begin
                if (r_bht[w_idx] != 2'b00) begin
                    r_bht[w_idx] <= r_bht[w_idx] - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed scenarios plus
// randomized branches checked against a behavioural reference model.
module tb_branch_resolve_ctrl;

    localparam int unsigned ENTRIES = 16;
    localparam int unsigned FC      = 2;
    localparam int unsigned CW      = 10;
    localparam int unsigned CMAX    = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          br_valid;
    logic          br_ready;
    logic [2:0]    br_funct3;
    logic [31:0]   br_pc;
    logic [31:0]   br_target;
    logic          br_pred_taken;
    logic          BrUn;
    logic          BrEq;
    logic          BrLT;
    logic [31:0]   fetch_pc;
    logic          fetch_pred_taken;
    logic          br_done;
    logic          br_taken;
    logic          br_illegal;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          flush;
    logic [CW-1:0] br_count;
    logic [CW-1:0] mispred_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int unsigned m_bht [ENTRIES];
    int unsigned m_br;
    int unsigned m_mis;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(
        .BHT_ENTRIES  (ENTRIES),
        .FLUSH_CYCLES (FC),
        .CNT_W        (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .br_valid         (br_valid),
        .br_ready         (br_ready),
        .br_funct3        (br_funct3),
        .br_pc            (br_pc),
        .br_target        (br_target),
        .br_pred_taken    (br_pred_taken),
        .BrUn             (BrUn),
        .BrEq             (BrEq),
        .BrLT             (BrLT),
        .fetch_pc         (fetch_pc),
        .fetch_pred_taken (fetch_pred_taken),
        .br_done          (br_done),
        .br_taken         (br_taken),
        .br_illegal       (br_illegal),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .br_count         (br_count),
        .mispred_count    (mispred_count)
    );

    // RV32I branch semantics on the actual operand values.
    function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return !($signed(a) < $signed(b));
            3'd6:    return a < b;
            3'd7:    return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit ref_legal(input logic [2:0] f3);
        return (f3 != 3'd2) && (f3 != 3'd3);
    endfunction

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % ENTRIES;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(ENTRIES); i++) m_bht[i] = 1;
        m_br  = 0;
        m_mis = 0;
    endtask

    // Runs one branch from acceptance through resolution (and flush if any).
    // Entered and left just after a falling edge.
    task automatic do_branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                             input logic pred, input logic [31:0] a, input logic [31:0] b);
        bit          exp_taken;
        bit          legal;
        bit          mis;
        logic [31:0] exp_rpc;
        int unsigned ix;
        int          k;
        exp_taken = ref_taken(f3, a, b);
        legal     = ref_legal(f3);
        mis       = (exp_taken != pred);
        exp_rpc   = exp_taken ? tgt : pc + 32'd4;
        ix        = idx_of(pc);

        k = 0;
        while (br_ready !== 1'b1 && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        checks++;
        if (br_ready !== 1'b1) begin errors++; $display("FAIL wait_ready: br_ready=%b after %0d cycles, want 1", br_ready, k); end

        br_valid = 1'b1; br_funct3 = f3; br_pc = pc; br_target = tgt; br_pred_taken = pred;
        @(posedge clk);
        @(negedge clk);
        br_valid = 1'b0;
        br_funct3 = 3'($urandom); br_pc = $urandom; br_target = $urandom; br_pred_taken = 1'($urandom);
        fetch_pc = pc;
        BrEq = (a == b);
        #1;
        // Act as the comparator in whatever mode the DUT requests
        BrLT = BrUn ? (a < b) : ($signed(a) < $signed(b));
        #1;
        checks++;
        if (br_done !== 1'b1) begin errors++; $display("FAIL eval_done: br_done=%b want 1", br_done); end
        checks++;
        if (br_taken !== exp_taken) begin errors++; $display("FAIL eval_taken f3=%0d: br_taken=%b want %b", f3, br_taken, exp_taken); end
        checks++;
        if (br_illegal !== !legal) begin errors++; $display("FAIL eval_illegal f3=%0d: br_illegal=%b want %b", f3, br_illegal, !legal); end
        checks++;
        if (BrUn !== f3[1]) begin errors++; $display("FAIL eval_brun f3=%0d: BrUn=%b want %b", f3, BrUn, f3[1]); end
        checks++;
        if (br_ready !== 1'b0) begin errors++; $display("FAIL eval_ready: br_ready=%b want 0", br_ready); end
        checks++;
        if (fetch_pred_taken !== (m_bht[ix] >= 2)) begin errors++; $display("FAIL eval_oldread idx=%0d: fetch_pred_taken=%b want %b", ix, fetch_pred_taken, m_bht[ix] >= 2); end

        if (legal) begin
            m_br = (m_br + 1) % (CMAX + 1);
            if (exp_taken) m_bht[ix] = (m_bht[ix] == 3) ? 3 : m_bht[ix] + 1;
            else           m_bht[ix] = (m_bht[ix] == 0) ? 0 : m_bht[ix] - 1;
        end
        if (mis) m_mis = (m_mis + 1) % (CMAX + 1);

        @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (fetch_pred_taken !== (m_bht[ix] >= 2)) begin errors++; $display("FAIL bht_update idx=%0d: fetch_pred_taken=%b want %b", ix, fetch_pred_taken, m_bht[ix] >= 2); end
        checks++;
        if (br_done !== 1'b0) begin errors++; $display("FAIL done_pulse: br_done=%b want 0", br_done); end
        if (mis) begin
            checks++;
            if (redirect_valid !== 1'b1) begin errors++; $display("FAIL redir_valid: redirect_valid=%b want 1", redirect_valid); end
            checks++;
            if (redirect_pc !== exp_rpc) begin errors++; $display("FAIL redir_pc: redirect_pc=%h want %h", redirect_pc, exp_rpc); end
            checks++;
            if (flush !== 1'b1) begin errors++; $display("FAIL flush_first: flush=%b want 1", flush); end
            checks++;
            if (br_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: br_ready=%b want 0", br_ready); end
            // A branch offered during FLUSH must be ignored
            br_valid = 1'b1; br_funct3 = 3'd0;
            for (int c = 1; c < int'(FC); c++) begin
                @(negedge clk); #1;
                checks++;
                if (flush !== 1'b1) begin errors++; $display("FAIL flush_hold c=%0d: flush=%b want 1", c, flush); end
                checks++;
                if (redirect_valid !== 1'b0) begin errors++; $display("FAIL redir_pulse c=%0d: redirect_valid=%b want 0", c, redirect_valid); end
                checks++;
                if (br_done !== 1'b0) begin errors++; $display("FAIL flush_ignore c=%0d: br_done=%b want 0", c, br_done); end
            end
            @(negedge clk);
            br_valid = 1'b0;
            #1;
            checks++;
            if (br_ready !== 1'b1) begin errors++; $display("FAIL flush_exit_ready: br_ready=%b want 1", br_ready); end
            checks++;
            if (flush !== 1'b0) begin errors++; $display("FAIL flush_exit: flush=%b want 0", flush); end
            checks++;
            if (br_done !== 1'b0) begin errors++; $display("FAIL flush_ignore_exit: br_done=%b want 0", br_done); end
        end else begin
            checks++;
            if (redirect_valid !== 1'b0) begin errors++; $display("FAIL no_redir: redirect_valid=%b want 0", redirect_valid); end
            checks++;
            if (flush !== 1'b0) begin errors++; $display("FAIL no_flush: flush=%b want 0", flush); end
            checks++;
            if (br_ready !== 1'b1) begin errors++; $display("FAIL ready_t2: br_ready=%b want 1", br_ready); end
        end
        checks++;
        if (br_count !== CW'(m_br)) begin errors++; $display("FAIL br_count: got %0d want %0d", br_count, m_br); end
        checks++;
        if (mispred_count !== CW'(m_mis)) begin errors++; $display("FAIL mispred_count: got %0d want %0d", mispred_count, m_mis); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; br_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            br_valid = 1'($urandom);
            #1;
            checks++;
            if (br_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_low: br_ready=%b want 0", br_ready); end
        end
        @(negedge clk);
        rst_n = 1'b1; br_valid = 1'b0;
        #1;
        model_reset();
        checks++;
        if (br_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: br_ready=%b want 1", br_ready); end
        checks++;
        if ({redirect_valid, flush, br_done, br_taken, br_illegal, BrUn} !== 6'b0) begin
            errors++; $display("FAIL rst_outs: rv/fl/done/tk/ill/un=%b want 000000", {redirect_valid, flush, br_done, br_taken, br_illegal, BrUn});
        end
        checks++;
        if (redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_rpc: redirect_pc=%h want 0", redirect_pc); end
        checks++;
        if (br_count !== '0 || mispred_count !== '0) begin errors++; $display("FAIL rst_counts: br=%0d mis=%0d want 0 0", br_count, mispred_count); end
        for (int i = 0; i < int'(ENTRIES); i++) begin
            fetch_pc = 32'(i * 4);
            #1;
            checks++;
            if (fetch_pred_taken !== 1'b0) begin errors++; $display("FAIL rst_bht idx=%0d: fetch_pred_taken=%b want 0", i, fetch_pred_taken); end
        end
    endtask

    task automatic test_beq_mispredict();
        do_branch(3'd0, 32'h100, 32'h140, 1'b0, 32'd5, 32'd5);
        fetch_pc = 32'h100; #1;
        checks++;
        if (fetch_pred_taken !== 1'b1) begin errors++; $display("FAIL beq_entry0: fetch_pred_taken=%b want 1", fetch_pred_taken); end
        checks++;
        if (mispred_count !== CW'(1)) begin errors++; $display("FAIL beq_mis: mispred_count=%0d want 1", mispred_count); end
    endtask

    task automatic test_bltu();
        do_branch(3'd6, 32'h200, 32'h300, 1'b0, 32'd9, 32'd3);
        checks++;
        if (br_count !== CW'(2)) begin errors++; $display("FAIL bltu_count: br_count=%0d want 2", br_count); end
    endtask

    task automatic test_train_bne();
        for (int n = 0; n < 3; n++) do_branch(3'd1, 32'h104, 32'h180, 1'b1, 32'd1, 32'd2);
        fetch_pc = 32'h104; #1;
        checks++;
        if (fetch_pred_taken !== 1'b1) begin errors++; $display("FAIL bne_trained: fetch_pred_taken=%b want 1", fetch_pred_taken); end
        do_branch(3'd1, 32'h104, 32'h180, 1'b1, 32'd7, 32'd7);
        fetch_pc = 32'h104; #1;
        checks++;
        if (fetch_pred_taken !== 1'b1) begin errors++; $display("FAIL bne_weak: fetch_pred_taken=%b want 1", fetch_pred_taken); end
    endtask

    task automatic test_illegal();
        do_branch(3'd2, 32'h300, 32'h400, 1'b1, $urandom, $urandom);
        do_branch(3'd3, 32'h304, 32'h480, 1'b0, $urandom, $urandom);
        do_branch(3'd3, 32'h308, 32'h500, 1'b1, 32'd4, 32'd4);
    endtask

    task automatic test_reset_abort();
        // Reset in the first FLUSH cycle
        while (br_ready !== 1'b1) begin @(negedge clk); #1; end
        br_valid = 1'b1; br_funct3 = 3'd0; br_pc = 32'h100; br_target = 32'h140; br_pred_taken = 1'b0;
        @(posedge clk); @(negedge clk);
        br_valid = 1'b0; BrEq = 1'b1; BrLT = 1'b0;
        @(posedge clk); @(negedge clk); #1;
        checks++;
        if (flush !== 1'b1 || redirect_valid !== 1'b1) begin errors++; $display("FAIL abort_pre: flush=%b rv=%b want 1 1", flush, redirect_valid); end
        rst_n = 1'b0; br_valid = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        checks++;
        if (flush !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL abort_flush: flush=%b rv=%b want 0 0", flush, redirect_valid); end
        checks++;
        if (br_count !== '0 || mispred_count !== '0) begin errors++; $display("FAIL abort_counts: br=%0d mis=%0d want 0 0", br_count, mispred_count); end
        rst_n = 1'b1; br_valid = 1'b0; #1;
        model_reset();
        checks++;
        if (br_ready !== 1'b1 || br_done !== 1'b0) begin errors++; $display("FAIL abort_idle: ready=%b done=%b want 1 0", br_ready, br_done); end
        // Reset during EVAL: no redirect and no BHT or counter update
        br_valid = 1'b1; br_funct3 = 3'd0; br_pc = 32'h100; br_target = 32'h140; br_pred_taken = 1'b0;
        @(posedge clk); @(negedge clk);
        br_valid = 1'b0; BrEq = 1'b1; rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1; fetch_pc = 32'h100; #1;
        checks++;
        if (flush !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL eval_abort_redir: flush=%b rv=%b want 0 0", flush, redirect_valid); end
        checks++;
        if (fetch_pred_taken !== 1'b0 || br_count !== '0 || mispred_count !== '0) begin
            errors++; $display("FAIL eval_abort_state: pred=%b br=%0d mis=%0d want 0 0 0", fetch_pred_taken, br_count, mispred_count);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int n = 0; n < 150; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ 32'h8000_0000;
                default: b = $urandom;
            endcase
            do_branch(3'($urandom), {$urandom_range(0, 255), 2'b00}, $urandom, 1'($urandom), a, b);
        end
    endtask

    task automatic test_wrap();
        for (int n = 0; n < 2000 && m_br != CMAX; n++) do_branch(3'd0, 32'h40, 32'h80, 1'b1, 32'd1, 32'd1);
        checks++;
        if (br_count !== CW'(CMAX)) begin errors++; $display("FAIL wrap_pre: br_count=%0d want %0d", br_count, CMAX); end
        do_branch(3'd0, 32'h40, 32'h80, 1'b1, 32'd1, 32'd1);
        checks++;
        if (br_count !== '0) begin errors++; $display("FAIL wrap: br_count=%0d want 0", br_count); end
    endtask

    initial begin
        rst_n = 1'b0; br_valid = 1'b0; br_funct3 = '0; br_pc = '0; br_target = '0;
        br_pred_taken = 1'b0; BrEq = 1'b0; BrLT = 1'b0; fetch_pc = '0;
        model_reset();
        test_reset();
        test_beq_mispredict();
        test_bltu();
        test_train_bne();
        test_illegal();
        test_reset_abort();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
